// File: rtl/spike_pkg.sv
// Shared definitions for the spike generator: FSM state encoding and the
// default counter width.
package spike_pkg;

  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_FIRE = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/spike_gen_if.sv
// Control/status bundle of the spike generator.
// Handshake: start is a one-cycle request sampled on the rising edge of clk
// and accepted only while busy is low (IDLE); it is dropped otherwise.
// stop is a one-cycle abort honoured only while a train is waiting or firing.
// done pulses for one cycle on normal completion. dbg_state mirrors the FSM.
interface spike_gen_if #(
  parameter int CNT_W = spike_pkg::CNT_W_DEF
) ();
  import spike_pkg::*;

  logic             tickIn;
  logic             start;
  logic             stop;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] width;
  logic [CNT_W-1:0] count;
  logic             spikeOut;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] spikeCnt;
  state_t           dbg_state;

  modport master (
    output tickIn, start, stop, period, width, count,
    input  spikeOut, busy, done, spikeCnt, dbg_state
  );

  modport slave (
    input  tickIn, start, stop, period, width, count,
    output spikeOut, busy, done, spikeCnt, dbg_state
  );

endinterface

// File: rtl/spike_gen_edge_sync.sv
// Synchronizes the divided-clock level into clk and emits a one-cycle pulse
// per rising edge. Latency is SYNC_STAGES edges from first high sample.
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Synchronizer chain plus previous-value flop for edge detection.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/spike_gen.sv
// Spike train generator: waits a programmable number of tick events between
// spike starts, drives each spike for a programmable number of clk cycles,
// and stops after a programmable number of spikes (0 = run forever).
module spike_gen
  import spike_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input logic        clk,
  input logic        reset,
  spike_gen_if.slave bus
);

  logic             tick;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] width_q, width_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [CNT_W-1:0] width_cnt_q, width_cnt_d;
  logic [CNT_W-1:0] spike_cnt_q, spike_cnt_d;
  // Set when the period elapsed while firing; forces a fire on return to WAIT.
  logic             pend_q, pend_d;
  logic             spike_q, busy_q, done_q;
  logic [CNT_W-1:0] tick_inc, spike_inc, width_last;

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .reset(reset),
    .in   (bus.tickIn),
    .pulse(tick)
  );

  assign tick_inc   = tick_cnt_q + 1'b1;
  assign spike_inc  = spike_cnt_q + 1'b1;
  assign width_last = width_q - 1'b1;

  // Next-state and counter logic; stop outranks tick and width expiry.
  always_comb begin
    state_d     = state_q;
    period_d    = period_q;
    width_d     = width_q;
    count_d     = count_q;
    tick_cnt_d  = tick_cnt_q;
    width_cnt_d = width_cnt_q;
    spike_cnt_d = spike_cnt_q;
    pend_d      = pend_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          period_d    = (bus.period == '0) ? CNT_W'(1) : bus.period;
          width_d     = (bus.width == '0) ? CNT_W'(1) : bus.width;
          count_d     = bus.count;
          spike_cnt_d = '0;
          tick_cnt_d  = '0;
          width_cnt_d = '0;
          pend_d      = 1'b0;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.stop) begin
          pend_d  = 1'b0;
          state_d = S_IDLE;
        end else if (pend_q) begin
          pend_d      = 1'b0;
          tick_cnt_d  = '0;
          width_cnt_d = '0;
          state_d     = S_FIRE;
        end else if (tick) begin
          if (tick_inc == period_q) begin
            tick_cnt_d  = '0;
            width_cnt_d = '0;
            state_d     = S_FIRE;
          end else begin
            tick_cnt_d = tick_inc;
          end
        end
      end
      S_FIRE: begin
        if (bus.stop) begin
          pend_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          if (tick) begin
            if (tick_inc == period_q) begin
              pend_d = 1'b1;
            end else begin
              tick_cnt_d = tick_inc;
            end
          end
          width_cnt_d = width_cnt_q + 1'b1;
          if (width_cnt_q == width_last) begin
            width_cnt_d = '0;
            spike_cnt_d = spike_inc;
            if ((count_q != '0) && (spike_inc == count_q)) begin
              state_d = S_DONE;
            end else begin
              state_d = S_WAIT;
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counter and registered-output update.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      period_q    <= '0;
      width_q     <= '0;
      count_q     <= '0;
      tick_cnt_q  <= '0;
      width_cnt_q <= '0;
      spike_cnt_q <= '0;
      pend_q      <= 1'b0;
      spike_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      period_q    <= period_d;
      width_q     <= width_d;
      count_q     <= count_d;
      tick_cnt_q  <= tick_cnt_d;
      width_cnt_q <= width_cnt_d;
      spike_cnt_q <= spike_cnt_d;
      pend_q      <= pend_d;
      spike_q     <= (state_d == S_FIRE);
      busy_q      <= (state_d != S_IDLE);
      done_q      <= (state_d == S_DONE);
    end
  end

  assign bus.spikeOut  = spike_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.spikeCnt  = spike_cnt_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_spike_gen.sv
// Directed bench for spike_gen: table of spike-train cases plus hand-written
// stop and reset sequences.
module tb_spike_gen;
  import spike_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  spike_gen_if #(.CNT_W(W)) bus ();

  spike_gen #(.CNT_W(W), .SYNC_STAGES(2)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    int p, w, c, gap, nt;
    int e_rise, e_w, e_sp, e_done, e_cnt, e_busy;
  } vec_t;

  vec_t vt[5];
  logic [W-1:0] exp_q[$];

  int errors = 0;
  int checks = 0;

  // Observed-waveform statistics, all maintained by sample().
  int   cyc, n_rise, n_done, rise_cyc, wmin, wmax, smin, smax, cnt257;
  logic sp_prev;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_stats();
    n_rise = 0; n_done = 0; rise_cyc = 0; cnt257 = -1;
    wmin = 1000000; wmax = 0; smin = 1000000; smax = 0;
    sp_prev = bus.spikeOut;
  endtask

  task automatic sample();
    @(negedge clk);
    cyc++;
    if (bus.spikeOut && !sp_prev) begin
      n_rise++;
      if (n_rise > 1) begin
        if (cyc - rise_cyc < smin) smin = cyc - rise_cyc;
        if (cyc - rise_cyc > smax) smax = cyc - rise_cyc;
      end
      rise_cyc = cyc;
      if (n_rise == 257) cnt257 = int'(bus.spikeCnt);
    end
    if (!bus.spikeOut && sp_prev) begin
      if (cyc - rise_cyc < wmin) wmin = cyc - rise_cyc;
      if (cyc - rise_cyc > wmax) wmax = cyc - rise_cyc;
    end
    if (bus.done) n_done++;
    sp_prev = bus.spikeOut;
  endtask

  task automatic cycle();
    @(posedge clk);
    sample();
  endtask

  task automatic run_ticks(input int n, input int gap, input int tail);
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < gap; j++) begin
        bus.tickIn = (j < gap / 2);
        cycle();
      end
    end
    bus.tickIn = 1'b0;
    for (int i = 0; i < tail; i++) cycle();
  endtask

  // Issue a start, then scramble the inputs to show they were latched.
  task automatic do_start(input int p, input int w, input int c);
    bus.period = W'(p);
    bus.width  = W'(w);
    bus.count  = W'(c);
    bus.start  = 1'b1;
    cycle();
    bus.start  = 1'b0;
    bus.period = 8'd7;
    bus.width  = 8'd9;
    bus.count  = 8'd0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bool_found_block : begin end
  end

  initial begin
    int found;
    cyc = 0;
    bus.tickIn = 1'b0; bus.start = 1'b0; bus.stop = 1'b0;
    bus.period = '0; bus.width = '0; bus.count = '0;
    reset = 1'b0;
    clear_stats();

    //         p  w   c  gap nt   rise w  sp  done cnt busy
    vt[0] = '{ 3, 4,  2, 10, 8,   2,   4, 30, 1,   2,  0 };
    vt[1] = '{ 0, 0,  1, 10, 3,   1,   1, 0,  1,   1,  0 };
    vt[2] = '{ 2, 3,  3, 6,  12,  3,   3, 12, 1,   3,  0 };
    vt[3] = '{ 1, 20, 3, 8,  10,  3,  20, 21, 1,   3,  0 };
    vt[4] = '{ 1, 2,  0, 4,  300, 300, 2, 4,  0,   44, 1 };

    // Reset state.
    repeat (3) cycle();
    check("rst_spikeOut", int'(bus.spikeOut), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_spikeCnt", int'(bus.spikeCnt), 0);
    check("rst_state", int'(bus.dbg_state), int'(S_IDLE));
    reset = 1'b1;
    repeat (4) cycle();

    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(W'(vt[i].e_cnt));
      check($sformatf("v%0d_idle_before", i), int'(bus.busy), 0);
      clear_stats();
      do_start(vt[i].p, vt[i].w, vt[i].c);
      run_ticks(vt[i].nt, vt[i].gap, 40);
      check($sformatf("v%0d_spikes", i), n_rise, vt[i].e_rise);
      check($sformatf("v%0d_wmin", i), wmin, vt[i].e_w);
      check($sformatf("v%0d_wmax", i), wmax, vt[i].e_w);
      if (vt[i].e_sp != 0) begin
        check($sformatf("v%0d_space_min", i), smin, vt[i].e_sp);
        check($sformatf("v%0d_space_max", i), smax, vt[i].e_sp);
      end
      check($sformatf("v%0d_done", i), n_done, vt[i].e_done);
      check($sformatf("v%0d_spikeCnt", i), int'(bus.spikeCnt), int'(exp_q.pop_front()));
      check($sformatf("v%0d_busy_end", i), int'(bus.busy), vt[i].e_busy);
      if (vt[i].e_rise > 256) check($sformatf("v%0d_wrap", i), cnt257, 0);
      if (vt[i].e_busy != 0) begin
        // Continuous train: abort from WAIT, count must hold.
        bus.stop = 1'b1;
        cycle();
        bus.stop = 1'b0;
        cycle();
        check($sformatf("v%0d_stop_busy", i), int'(bus.busy), 0);
        check($sformatf("v%0d_stop_cnt", i), int'(bus.spikeCnt), vt[i].e_cnt);
      end
    end

    // Stop during the second cycle of the second spike.
    clear_stats();
    do_start(1, 5, 0);
    found = 0;
    for (int k = 0; k < 200; k++) begin
      bus.tickIn = ((k % 8) < 4);
      cycle();
      if (n_rise == 2 && bus.spikeOut) begin
        found = 1;
        break;
      end
    end
    bus.tickIn = 1'b0;
    check("stop_reach_fire", found, 1);
    cycle();
    check("stop_fire_cycle2", int'(bus.spikeOut), 1);
    bus.stop = 1'b1;
    cycle();
    bus.stop = 1'b0;
    check("stop_spikeOut", int'(bus.spikeOut), 0);
    check("stop_busy", int'(bus.busy), 0);
    check("stop_spikeCnt", int'(bus.spikeCnt), 1);
    repeat (20) cycle();
    check("stop_no_done", n_done, 0);
    check("stop_cnt_hold", int'(bus.spikeCnt), 1);

    // Reset mid-FIRE, then a start issued while busy must be ignored.
    clear_stats();
    do_start(1, 8, 0);
    bus.tickIn = 1'b1;
    found = 0;
    for (int k = 0; k < 50; k++) begin
      cycle();
      if (bus.spikeOut) begin
        found = 1;
        break;
      end
    end
    check("rst_reach_fire", found, 1);
    cycle();
    bus.tickIn = 1'b0;
    reset = 1'b0;
    cycle();
    check("midrst_spikeOut", int'(bus.spikeOut), 0);
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_done", int'(bus.done), 0);
    check("midrst_spikeCnt", int'(bus.spikeCnt), 0);
    check("midrst_state", int'(bus.dbg_state), int'(S_IDLE));
    reset = 1'b1;
    repeat (3) cycle();
    check("midrst_no_done", n_done, 0);
    clear_stats();
    do_start(1, 3, 2);
    check("restart_busy", int'(bus.busy), 1);
    bus.period = 8'd1; bus.width = 8'd6; bus.count = 8'd1;
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    run_ticks(6, 10, 40);
    check("restart_spikes", n_rise, 2);
    check("restart_width", wmax, 3);
    check("restart_done", n_done, 1);
    check("restart_spikeCnt", int'(bus.spikeCnt), 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
